// File: rtl/dmem_seq_if.sv
// Bus bundle between the Y86 memory-stage sequencer and its control/RAM side.
// slave is the sequencer's view; master is the view of whoever drives it.
interface dmem_seq_if #(
    parameter int AW = 10
);
    logic          start;
    logic [3:0]    icode;
    logic [63:0]   valE;
    logic [63:0]   valA;
    logic [63:0]   valP;
    logic          busy;
    logic          done;
    logic [63:0]   valM;
    logic          dmem_error;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    modport slave (
        input  start, icode, valE, valA, valP, ram_rdata,
        output busy, done, valM, dmem_error, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output start, icode, valE, valA, valP, ram_rdata,
        input  busy, done, valM, dmem_error, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/dmem_seq_ctrl.sv
// Y86 memory-stage sequencer: moves one 64-bit quadword through a byte-wide
// registered-read RAM, one byte per beat, little-endian.
//
// state   | meaning
// IDLE    | waiting for start; latches op, base address and write data
// XFER    | 8 beats k=0..7 on the RAM port (write bytes or issue reads)
// CAPTURE | read only: collects byte 7 returned from the last XFER beat
// DONE    | one-cycle done pulse, then back to IDLE
module dmem_seq_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic      clk,
    input  logic      reset,
    dmem_seq_if.slave mem
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_XFER    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // Highest legal base for an 8-byte access, compared at full 64-bit width.
    localparam logic [63:0] MAX_BASE = 64'(MEM_BYTES) - 64'd8;

    state_t        state_q, state_d;
    op_t           op_q;
    logic [2:0]    k_q;
    logic [AW-1:0] base_q;
    logic [63:0]   wdata_q;
    logic [63:0]   valm_q;
    logic          err_q;

    op_t           dec_op;
    logic [63:0]   dec_base;
    logic [63:0]   dec_wdata;
    logic          dec_fault;
    logic          accept;
    logic          capture_en;
    logic [2:0]    cap_idx;

    always_comb begin
        dec_op    = OP_NONE;
        dec_base  = mem.valE;
        dec_wdata = mem.valA;
        case (mem.icode)
            4'h4: dec_op = OP_WRITE;
            4'h5: dec_op = OP_READ;
            4'h8: begin
                dec_op    = OP_WRITE;
                dec_wdata = mem.valP;
            end
            4'h9: begin
                dec_op   = OP_READ;
                dec_base = mem.valA;
            end
            4'hA: dec_op = OP_WRITE;
            4'hB: begin
                dec_op   = OP_READ;
                dec_base = mem.valA;
            end
            default: dec_op = OP_NONE;
        endcase
    end

    assign dec_fault = (dec_op != OP_NONE) && (dec_base > MAX_BASE);
    assign accept    = (state_q == S_IDLE) && mem.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem.start) begin
                    if (dec_op == OP_NONE || dec_fault) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (k_q == 3'd7) begin
                    state_d = (op_q == OP_WRITE) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Registered-read RAM: the byte addressed in beat k arrives during beat k+1.
    assign capture_en = (op_q == OP_READ) &&
                        (((state_q == S_XFER) && (k_q != 3'd0)) || (state_q == S_CAPTURE));
    assign cap_idx    = (state_q == S_CAPTURE) ? 3'd7 : (k_q - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_NONE;
            k_q     <= 3'd0;
            base_q  <= '0;
            wdata_q <= 64'd0;
            valm_q  <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= dec_op;
                base_q  <= dec_base[AW-1:0];
                wdata_q <= dec_wdata;
                err_q   <= dec_fault;
                k_q     <= 3'd0;
            end else if (state_q == S_XFER) begin
                k_q <= k_q + 3'd1;
            end
            if (capture_en) begin
                valm_q[{cap_idx, 3'b000} +: 8] <= mem.ram_rdata;
            end
        end
    end

    always_comb begin
        mem.busy      = (state_q != S_IDLE);
        mem.done      = (state_q == S_DONE);
        mem.ram_we    = 1'b0;
        mem.ram_addr  = '0;
        mem.ram_wdata = 8'd0;
        if (state_q == S_XFER) begin
            mem.ram_addr = base_q + AW'(k_q);
            if (op_q == OP_WRITE) begin
                mem.ram_we    = 1'b1;
                mem.ram_wdata = wdata_q[{k_q, 3'b000} +: 8];
            end
        end
    end

    assign mem.valM       = valm_q;
    assign mem.dmem_error = err_q;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Bench for dmem_seq_ctrl: directed scenarios plus random ops against a
// quadword-level memory model, with a registered-read byte RAM attached.
module tb_dmem_seq_ctrl;

    localparam int MEM_BYTES = 1024;
    localparam int AW        = 10;

    logic clk = 1'b0;
    logic reset;
    logic ram_clr;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  ram     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [63:0] ref_valm;
    logic        ref_err;

    dmem_seq_if #(.AW(AW)) bus ();

    dmem_seq_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < MEM_BYTES; i++) ram[i] <= 8'd0;
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.icode = 4'($urandom);
        bus.valE  = {$urandom, $urandom};
        bus.valA  = {$urandom, $urandom};
        bus.valP  = {$urandom, $urandom};
    endtask

    // One instruction: model result from the op rules, then compare the DUT.
    task automatic run_op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                          input logic [63:0] vp, input int extra_start_cyc);
        int          kind;   // 0 none, 1 read, 2 write
        logic [63:0] base;
        logic [63:0] wd;
        logic        fault;
        int          exp_lat;
        int          we_cnt;
        int          done_cyc;
        int          cyc;
        int          busy_cnt;
        logic [63:0] got;
        kind = 0; base = ve; wd = va;
        case (ic)
            4'h4, 4'hA: kind = 2;
            4'h8: begin kind = 2; wd = vp; end
            4'h5: kind = 1;
            4'h9, 4'hB: begin kind = 1; base = va; end
            default: kind = 0;
        endcase
        fault   = (kind != 0) && (base > 64'(MEM_BYTES - 8));
        exp_lat = (kind == 0 || fault) ? 1 : ((kind == 2) ? 9 : 10);

        @(negedge clk);
        bus.start = 1'b1;
        bus.icode = ic; bus.valE = ve; bus.valA = va; bus.valP = vp;
        @(negedge clk);
        scramble_inputs();
        cyc = 1; done_cyc = 0; we_cnt = 0;
        while (done_cyc == 0 && cyc <= 20) begin
            bus.start = (cyc == extra_start_cyc);
            if (bus.ram_we === 1'b1) begin
                we_cnt++;
                if (kind == 2 && !fault && we_cnt <= 8) begin
                    check("wr_addr", 64'(bus.ram_addr), (base + 64'(we_cnt - 1)) & 64'(MEM_BYTES - 1));
                    check("wr_data", 64'(bus.ram_wdata), (wd >> (8 * (we_cnt - 1))) & 64'hFF);
                end
            end
            if (bus.done === 1'b1) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;

        ref_err = fault;
        if (kind == 2 && !fault) begin
            for (int i = 0; i < 8; i++) ref_mem[32'(base) + i] = wd[8*i +: 8];
        end else if (kind == 1 && !fault) begin
            for (int i = 0; i < 8; i++) ref_valm[8*i +: 8] = ref_mem[32'(base) + i];
        end

        check("latency", 64'(done_cyc), 64'(exp_lat));
        check("we_beats", 64'(we_cnt), (kind == 2 && !fault) ? 64'd8 : 64'd0);
        check("dmem_error", 64'(bus.dmem_error), 64'(ref_err));
        check("valM", bus.valM, ref_valm);
        if (kind == 2 && !fault) begin
            for (int i = 0; i < 8; i++) got[8*i +: 8] = ram[32'(base) + i];
            check("ram_bytes", got, wd);
        end

        @(negedge clk);
        check("done_pulse_len", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
        check("error_hold", 64'(bus.dmem_error), 64'(ref_err));
        if (extra_start_cyc > 0) begin
            busy_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_cnt++;
            end
            check("no_queued_start", 64'(busy_cnt), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] addr;
        logic [3:0]  ic;
        int          sel;
        int          act;
        bus.start = 1'b0;
        bus.icode = 4'd0; bus.valE = 64'd0; bus.valA = 64'd0; bus.valP = 64'd0;
        reset = 1'b1; ram_clr = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
        ref_valm = 64'd0; ref_err = 1'b0;
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_valM", bus.valM, 64'd0);
        check("rst_err", 64'(bus.dmem_error), 64'd0);
        check("rst_we", 64'(bus.ram_we), 64'd0);
        check("rst_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_wdata", 64'(bus.ram_wdata), 64'd0);

        // reset wins over a simultaneous start
        bus.start = 1'b1; bus.icode = 4'h4; bus.valE = 64'd16;
        @(negedge clk);
        check("rst_prio_busy", 64'(bus.busy), 64'd0);
        check("rst_prio_we", 64'(bus.ram_we), 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;

        run_op(4'h4, 64'd16, 64'h0807060504030201, 64'd0, 0);
        run_op(4'h5, 64'd16, 64'd0, 64'd0, 0);
        check("rmmov_mrmov_valM", bus.valM, 64'h0807060504030201);
        run_op(4'hA, 64'd100, 64'd12, 64'd0, 0);
        run_op(4'hB, 64'd0, 64'd100, 64'd0, 0);
        check("push_pop_valM", bus.valM, 64'd12);
        run_op(4'h8, 64'd200, 64'd0, 64'd2, 0);
        run_op(4'h5, 64'd1020, 64'd0, 64'd0, 0);
        run_op(4'h3, 64'd0, 64'd0, 64'd0, 0);
        run_op(4'h4, 64'd1016, 64'hA1B2C3D4E5F60718, 64'd0, 0);
        run_op(4'h9, 64'd0, 64'd1016, 64'd0, 0);
        run_op(4'hB, 64'd0, 64'd1017, 64'd0, 0);
        run_op(4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 0);
        run_op(4'h4, 64'd40, 64'h1122334455667788, 64'd0, 3);

        // reset during cycle 4 of a read aborts it
        @(negedge clk);
        bus.start = 1'b1; bus.icode = 4'h5; bus.valE = 64'd40;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_we", 64'(bus.ram_we), 64'd0);
        check("abort_valM", bus.valM, 64'd0);
        reset = 1'b0;
        ref_valm = 64'd0; ref_err = 1'b0;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) act++;
        end
        check("abort_no_done", 64'(act), 64'd0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: ic = 4'h4;
                1: ic = 4'h5;
                2: ic = 4'h8;
                3: ic = 4'h9;
                4: ic = 4'hA;
                5: ic = 4'hB;
                default: ic = 4'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0) addr = 64'($urandom_range(0, 7)) * 64'd8 + 64'($urandom_range(0, 3));
            else begin
                case ($urandom_range(0, 4))
                    0: addr = 64'd1016;
                    1: addr = 64'd1017;
                    2: addr = 64'd1023;
                    3: addr = 64'hFFFF_FFFF_FFFF_FFFF;
                    default: addr = {$urandom, $urandom};
                endcase
            end
            run_op(ic, addr, ((ic == 4'h9) || (ic == 4'hB)) ? addr : {$urandom, $urandom},
                   {$urandom, $urandom}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_seq_ctrl.md
DMEM_SEQ_CTRL -- requirements
Module: dmem_seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: size of the byte-wide data RAM in bytes.
REQ-002 SHALL have parameter AW, default 10: RAM address width, with 2^AW >= MEM_BYTES.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to execute the memory stage for the current instruction; sampled only in IDLE.
REQ-007 icode  in  4  Y86 instruction code.
REQ-008 valE  in  64  ALU result.
REQ-009 valA  in  64  register A value.
REQ-010 valP  in  64  next-PC value.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 valM  out  64  assembled load data.
REQ-014 dmem_error  out  1  address fault flag.
REQ-015 ram_addr  out  AW  byte address to the RAM.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_wdata  out  8  RAM write byte.
REQ-018 ram_rdata  in  8  RAM read byte; valid one cycle after ram_addr is presented (registered read).

Function
REQ-019 SHALL decode the operation from icode as follows:
- 4 rmmovq: write valA to M[valE].
- 5 mrmovq: read M[valE].
- 8 call: write valP to M[valE].
- 9 ret: read M[valA].
- A pushq: write valA to M[valE].
- B popq: read M[valA].
- Any other icode: no memory operation.
REQ-020 SHALL latch icode, the selected base address and the selected write data in the cycle start is accepted in IDLE; later input changes SHALL have no effect on the operation in progress.
REQ-021 SHALL implement the states IDLE, XFER, CAPTURE and DONE.
REQ-022 IDLE -> DONE on start when the op is none or the address faults; IDLE -> XFER on start for a valid memory op.
REQ-023 XFER SHALL run exactly 8 cycles under a 3-bit beat counter k = 0..7, presenting ram_addr = base[AW-1:0] + k.
REQ-024 Writes SHALL drive ram_we=1 and ram_wdata = wdata[8k+7:8k] in each XFER beat (little-endian), then go XFER -> DONE after k=7.
REQ-025 Reads SHALL hold ram_we=0, capture ram_rdata into valM[8(k-1)+7:8(k-1)] in XFER beats k=1..7, then go XFER -> CAPTURE -> DONE, with CAPTURE capturing byte 7.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next cycle.
REQ-027 Latency, counting start accepted at edge 0: none/fault gives done in cycle 1; a write gives done in cycle 9; a read gives done in cycle 10.
REQ-028 An address SHALL fault when base > MEM_BYTES-8; this check SHALL use the full 64-bit base with no wrap, so a base of 2^64-1 faults.
REQ-029 On a fault, SHALL set dmem_error=1 with done, make no RAM access (ram_we never asserted) and leave valM unchanged.
REQ-030 dmem_error SHALL hold its value until the next accepted start, which clears it.
REQ-031 valM SHALL change only during a read transfer and SHALL hold its value otherwise, including across writes and non-memory ops.
REQ-032 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 ram_we SHALL be 0 in every state except XFER-write; ram_addr and ram_wdata SHALL be 0 outside XFER.

Reset
REQ-034 reset SHALL force the state to IDLE, the beat counter to 0, and busy, done, dmem_error, ram_we, ram_addr, ram_wdata and valM all to 0 at the next clk edge.
REQ-035 reset asserted mid-transfer SHALL abort the operation, with ram_we=0 from the next cycle and no done pulse.
REQ-036 reset SHALL take priority over start in the same cycle.

Verification
REQ-037 Write: rmmovq, icode=4, valE=16, valA=64'h0807060504030201 -> ram_we in cycles 1-8, RAM bytes 16..23 = 01..08, done in cycle 9, dmem_error=0.
REQ-038 Read: mrmovq, icode=5, valE=16, after REQ-037 -> ram_we never asserted, done in cycle 10, valM=64'h0807060504030201.
REQ-039 Stack ops: pushq icode=A with valE=100 and valA=12, then popq icode=B with valA=100 -> valM=12; call icode=8 with valE=200 and valP=2 writes 2 at addresses 200..207.
REQ-040 Fault and non-memory op:
- mrmovq with valE=1020 -> done in cycle 1, dmem_error=1, valM unchanged.
- A following start with icode=3 -> done in cycle 1, dmem_error=0.
REQ-041 Mid-operation events:
- start pulsed again in cycle 3 of a write -> ignored, exactly one done.
- reset in cycle 4 of a read -> IDLE, busy=0, no done, valM=0.
